// File: rtl/mem_rw_responder.sv
// mem_rw_responder: memory target answering read/write requests on a
// valid/ready channel with one in-order response per request.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   req_valid/req_ready  request handshake
//   req_we               1 = write, 0 = read
//   req_addr             word address
//   req_wdata            write data (ignored for reads)
//   rsp_valid/rsp_ready  response handshake
//   rsp_we               echo of req_we
//   rsp_rdata            mem[addr] as it was before this request's write
//   rsp_err              address was >= DEPTH
//   busy                 clear sweep running
//
// Optional feature macro: MEM_RW_CLEAR_EN
//   Zeroes the whole array one word per cycle after every reset.
//   While the sweep runs, busy=1 and no requests are taken.
module mem_rw_responder #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_we,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic [1:0]        count;
    logic              s1_we;
    logic              s1_err;
    logic [DATA_W-1:0] s1_rdata;

    logic              in_range;
    logic              push;
    logic              pop;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] rd_now;

    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_data;

    assign in_range  = {1'b0, req_addr} < LIMIT;
    assign idx       = req_addr[IDX_W-1:0];
    assign rd_now    = in_range ? mem[idx] : '0;

    assign rsp_valid = (count != 2'd0);
    assign pop       = rsp_valid & rsp_ready;
    assign req_ready = ((count < 2'd2) || pop) && !busy;
    assign push      = req_valid & req_ready;

`ifdef MEM_RW_CLEAR_EN
    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] clr_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLEAR;
            busy     <= 1'b1;
            clr_addr <= '0;
        end else if (state == CLEAR) begin
            if (clr_addr == IDX_W'(DEPTH - 1)) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                clr_addr <= clr_addr + 1'b1;
            end
        end
    end
`else
    assign busy = 1'b0;
`endif

    // Single write port shared by the sweep and accepted writes; the two
    // never overlap because requests are blocked while busy.
    always_comb begin
        wr_en   = !rst && push && req_we && in_range;
        wr_idx  = idx;
        wr_data = req_wdata;
`ifdef MEM_RW_CLEAR_EN
        if (!rst && state == CLEAR) begin
            wr_en   = 1'b1;
            wr_idx  = clr_addr;
            wr_data = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Two-entry response FIFO; the head entry drives rsp_* directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= 2'd0;
            rsp_we    <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            s1_we     <= 1'b0;
            s1_rdata  <= '0;
            s1_err    <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        rsp_we    <= req_we;
                        rsp_rdata <= rd_now;
                        rsp_err   <= !in_range;
                    end else begin
                        s1_we    <= req_we;
                        s1_rdata <= rd_now;
                        s1_err   <= !in_range;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    rsp_we    <= s1_we;
                    rsp_rdata <= s1_rdata;
                    rsp_err   <= s1_err;
                    count     <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        rsp_we    <= req_we;
                        rsp_rdata <= rd_now;
                        rsp_err   <= !in_range;
                    end else begin
                        rsp_we    <= s1_we;
                        rsp_rdata <= s1_rdata;
                        rsp_err   <= s1_err;
                        s1_we     <= req_we;
                        s1_rdata  <= rd_now;
                        s1_err    <= !in_range;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_rw_responder.sv
// tb_mem_rw_responder: directed and random traffic against a queue-based
// reference model of the responder.
module tb_mem_rw_responder;

    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 200;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_we;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          busy;

    always #5 clk = ~clk;

    mem_rw_responder #(
        .DATA_W(DW),
        .ADDR_W(AW),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_we   (rsp_we),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .busy     (busy)
    );

    typedef struct {
        logic          we;
        logic [DW-1:0] rd;
        logic          err;
        bit            known;
    } rsp_t;

    logic [DW-1:0] mm [0:255];
    bit            kn [0:255];
    rsp_t          q[$];
    int            checks = 0;
    int            errors = 0;
    int            acc_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, compare against model, advance.
    task automatic step(input logic v, input logic we,
                        input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic rr);
        rsp_t e;
        bit   pop;
        bit   acc;
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        rsp_ready = rr;
        #1;
        pop = (q.size() != 0) && rr;
        chk("rsp_valid", rsp_valid, q.size() != 0);
        chk("req_ready", req_ready, (q.size() < 2) || pop);
        if (q.size() != 0) begin
            e = q[0];
            chk("rsp_we", rsp_we, e.we);
            chk("rsp_err", rsp_err, e.err);
            if (e.known) chk("rsp_rdata", rsp_rdata, e.rd);
        end
        if (pop) void'(q.pop_front());
        acc = v && req_ready;
        if (acc) begin
            acc_cnt++;
            e.we  = we;
            e.err = (int'(a) >= DEPTH);
            if (e.err) begin
                e.rd    = '0;
                e.known = 1'b1;
            end else begin
                e.rd    = mm[a];
                e.known = kn[a];
                if (we) begin
                    mm[a] = d;
                    kn[a] = 1'b1;
                end
            end
            q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && q.size() != 0; i++) step(1'b0, 1'b0, '0, '0, 1'b1);
        chk("drain", q.size(), 0);
    endtask

    task automatic do_reset();
        int n;
        rst       = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        n = 0;
`ifdef MEM_RW_CLEAR_EN
        chk("ready_in_sweep", req_ready, 0);
        while (busy && n < DEPTH + 8) begin
            n++;
            @(posedge clk);
            @(negedge clk);
        end
        chk("busy_len", n, DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            mm[i] = '0;
            kn[i] = 1'b1;
        end
`endif
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_we", rsp_we, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
    endtask

    initial begin
        int c0;
        logic [AW-1:0] a;
        for (int i = 0; i < 256; i++) begin
            mm[i] = '0;
            kn[i] = 1'b0;
        end
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        do_reset();

        // write 0 then read at 5
        step(1'b1, 1'b1, 8'd5, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'd5, 8'h00, 1'b1);
        drain();

        // write then back-to-back read, one-cycle latency
        step(1'b1, 1'b1, 8'd5, 8'h05, 1'b1);
        step(1'b1, 1'b0, 8'd5, 8'h00, 1'b1);
        #1;
        chk("lat_valid", rsp_valid, 1);
        chk("lat_rdata", rsp_rdata, 8'h05);
        drain();

        // back-pressure: three reads with rsp_ready low
        step(1'b1, 1'b1, 8'd6, 8'h66, 1'b1);
        step(1'b1, 1'b1, 8'd7, 8'h77, 1'b1);
        drain();
        c0 = acc_cnt;
        step(1'b1, 1'b0, 8'd5, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'd6, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'd7, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'd7, 8'h00, 1'b0);
        chk("bp_accepts", acc_cnt - c0, 2);
        step(1'b1, 1'b0, 8'd7, 8'h00, 1'b1);
        drain();
        chk("bp_total", acc_cnt - c0, 3);

        // out of range write/read, in-range neighbour untouched
        step(1'b1, 1'b1, 8'd50, 8'h50, 1'b1);
        step(1'b1, 1'b1, 8'd250, 8'hAA, 1'b1);
        step(1'b1, 1'b0, 8'd250, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'd50, 8'h00, 1'b1);
        step(1'b1, 1'b1, 8'd200, 8'h11, 1'b1);
        step(1'b1, 1'b0, 8'd199, 8'h00, 1'b1);
        drain();

        // streaming 256 writes then 256 reads
        c0 = acc_cnt;
        for (int i = 0; i < 256; i++) begin
            a = AW'(i);
            step(1'b1, 1'b1, a, a ^ 8'h3C, 1'b1);
        end
        for (int i = 0; i < 256; i++) begin
            a = AW'(i);
            step(1'b1, 1'b0, a, 8'h00, 1'b1);
        end
        chk("stream_rate", acc_cnt - c0, 512);
        drain();

        // reset mid-operation: pending responses lost, memory kept
        step(1'b1, 1'b1, 8'd10, 8'h77, 1'b0);
        step(1'b1, 1'b0, 8'd10, 8'h00, 1'b0);
        do_reset();
        step(1'b1, 1'b0, 8'd10, 8'h00, 1'b1);
        drain();

`ifdef MEM_RW_CLEAR_EN
        // sweep interrupted part way restarts from zero
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("busy_mid", busy, 1);
        do_reset();
        step(1'b1, 1'b0, 8'd0, 8'h00, 1'b1);
        step(1'b1, 1'b0, AW'(DEPTH - 1), 8'h00, 1'b1);
        drain();
`endif

        // random traffic
        for (int i = 0; i < 600; i++) begin
            a = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 15))
                                           : AW'($urandom_range(0, 255));
            step(($urandom_range(0, 3) != 0), $urandom_range(0, 1), a,
                 DW'($urandom), ($urandom_range(0, 2) != 0));
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
